// File: rtl/iob_eth_mem_bridge.sv
// -----------------------------------------------------------------------------
// iob_eth_mem_bridge
//
// Bridges the Ethernet core's IOb master port onto the system memory bus.
// The Ethernet DMA sees a 2^WINDOW_W byte window. Each in-window request is
// relocated to cfg_base + offset (modulo 2^ADDR_W) and issued downstream.
// Out-of-window requests are refused locally: they complete with zero read
// data and raise the sticky error flag. Only one transaction is in flight at
// a time.
//
// Optional feature: define ETH_MEM_TIMEOUT_EN to compile in a watchdog that
// aborts a downstream access that is not acknowledged within TIMEOUT cycles.
//
// Ports
//   clk        : clock
//   rst        : synchronous reset, active low
//   cfg_base   : relocation base address (sampled only when a request is taken)
//   s_*        : IOb slave side (from Ethernet core)
//                s_valid/s_addr/s_wdata/s_wstrb in, s_rdata/s_ready out
//   m_*        : IOb master side (to system memory)
//                m_valid/m_addr/m_wdata/m_wstrb out, m_rdata/m_ready in
//   err_o      : sticky error flag
//   err_cnt_o  : saturating count of refused or aborted accesses
//   err_clr    : clears err_o and err_cnt_o
// -----------------------------------------------------------------------------
module iob_eth_mem_bridge #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 24,
    parameter int WINDOW_W = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     cfg_base,
    // upstream IOb slave
    input  logic                  s_valid,
    input  logic [31:0]           s_addr,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    output logic [DATA_W-1:0]     s_rdata,
    output logic                  s_ready,
    // downstream IOb master
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ready,
    // error reporting
    output logic                  err_o,
    output logic [7:0]            err_cnt_o,
    input  logic                  err_clr
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
    logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                err_event;

    logic                in_window;
    logic [ADDR_W-1:0]   offset_ext;

    assign in_window  = (s_addr[31:WINDOW_W] == '0);
    assign offset_ext = ADDR_W'(s_addr[WINDOW_W-1:0]);

`ifdef ETH_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`else
    // Keeps the parameter referenced when the watchdog is compiled out.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        s_rdata_d = s_rdata_q;
        err_event = 1'b0;
`ifdef ETH_MEM_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    if (in_window) begin
                        m_addr_d  = cfg_base + offset_ext;
                        m_wdata_d = s_wdata;
                        m_wstrb_d = s_wstrb;
`ifdef ETH_MEM_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                        state_d   = ISSUE;
                    end else begin
                        // Refused locally: nothing goes downstream.
                        s_rdata_d = '0;
                        err_event = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            ISSUE: begin
                if (m_ready) begin
                    // A zero strobe marks a read; writes return zero data.
                    s_rdata_d = (m_wstrb_q == '0) ? m_rdata : '0;
                    state_d   = DONE;
                end
`ifdef ETH_MEM_TIMEOUT_EN
                // This cycle's increment would reach TIMEOUT: abort. An
                // acknowledge in the same cycle wins (handled above).
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    s_rdata_d = '0;
                    err_event = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Error bookkeeping: a new error beats a simultaneous clear.
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_d     = err_event;
            err_cnt_d = err_event ? 8'd1 : 8'd0;
        end else if (err_event) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            s_rdata_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
`ifdef ETH_MEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            s_rdata_q <= s_rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`ifdef ETH_MEM_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Handshake outputs follow the registered state directly.
    assign m_valid   = (state_q == ISSUE);
    assign s_ready   = (state_q == DONE);
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign s_rdata   = s_rdata_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule
